// File: rtl/npc_lsu.sv
// Load/store unit between the npc execute stage and a handshaked data-memory port.
// Latency: 3 cycles best case (1 for misaligned/illegal); one access in flight; mem_valid holds until mem_ready, resp_valid holds until resp_ready.
module npc_lsu #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [1:0]        resp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wmask,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_funct3;
  logic              r_wen;
  logic [OFFW-1:0]   r_off;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_resp_rdata;
  logic [1:0]        r_resp_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [XLEN-1:0]   r_mem_wdata;
  logic [NB-1:0]     r_mem_wmask;
  logic              r_mem_wen;

  logic [OFFW-1:0]   w_req_off;
  logic [OFFW-1:0]   w_amask;
  logic [NB-1:0]     w_bmask;
  logic              w_legal;
  logic              w_mis;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_timeout;
  logic [XLEN-1:0]   w_shift;
  logic [XLEN-1:0]   w_lmask;
  logic              w_sbit;
  logic [XLEN-1:0]   w_load_data;

  assign w_req_off = req_addr[OFFW-1:0];

  always_comb begin
    w_legal = 1'b0;
    if (req_wen) begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010: w_legal = 1'b1;
        3'b011:                 w_legal = (XLEN == 64);
        default:                w_legal = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
        3'b011, 3'b110:                         w_legal = (XLEN == 64);
        default:                                w_legal = 1'b0;
      endcase
    end
  end

  // w_amask: low offset bits that must be zero; w_bmask: size-wide byte enables
  always_comb begin
    w_amask = '0;
    w_bmask = '0;
    for (int i = 0; i < OFFW; i++) w_amask[i] = (i < int'(req_funct3[1:0]));
    for (int i = 0; i < NB; i++)   w_bmask[i] = (i < (1 << req_funct3[1:0]));
  end

  assign w_mis = |(w_req_off & w_amask);

  // Counter includes the current cycle, so exactly TIMEOUT cycles are spent in REQ+WAIT
  assign w_cnt_nxt = r_cnt + CW'(1);
  assign w_timeout = (w_cnt_nxt >= CW'(TIMEOUT));

  assign w_shift = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_lmask = '1;
    w_sbit  = w_shift[XLEN-1];
    case (r_funct3[1:0])
      2'd0: begin w_lmask = XLEN'(8'hFF);         w_sbit = w_shift[7];  end
      2'd1: begin w_lmask = XLEN'(16'hFFFF);      w_sbit = w_shift[15]; end
      2'd2: begin w_lmask = XLEN'(32'hFFFF_FFFF); w_sbit = w_shift[31]; end
      default: ;
    endcase
    w_load_data = (w_shift & w_lmask) | ((!r_funct3[2] && w_sbit) ? ~w_lmask : '0);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_state_nxt = (!w_legal || w_mis) ? S_RESP : S_REQ;
      S_REQ: begin
        if (mem_ready)      w_state_nxt = S_WAIT;
        else if (w_timeout) w_state_nxt = S_RESP;
      end
      S_WAIT: if (mem_rvalid || w_timeout) w_state_nxt = S_RESP;
      S_RESP: if (resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_funct3     <= '0;
      r_wen        <= 1'b0;
      r_off        <= '0;
      r_cnt        <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= 2'b00;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wmask  <= '0;
      r_mem_wen    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_funct3     <= req_funct3;
          r_wen        <= req_wen;
          r_off        <= w_req_off;
          r_cnt        <= '0;
          r_resp_rdata <= '0;
          r_resp_err   <= !w_legal ? 2'b11 : (w_mis ? 2'b01 : 2'b00);
          r_mem_addr   <= {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
          r_mem_wen    <= req_wen;
          r_mem_wdata  <= req_wen ? (req_wdata << {w_req_off, 3'b000}) : '0;
          r_mem_wmask  <= req_wen ? (w_bmask << w_req_off) : '0;
        end
        S_REQ: begin
          r_cnt <= w_cnt_nxt;
          if (!mem_ready && w_timeout) r_resp_err <= 2'b10;
        end
        S_WAIT: begin
          r_cnt <= w_cnt_nxt;
          if (mem_rvalid)     r_resp_rdata <= r_wen ? '0 : w_load_data;
          else if (w_timeout) r_resp_err   <= 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign mem_valid  = (r_state == S_REQ);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_addr   = r_mem_addr;
  assign mem_wen    = r_mem_wen;
  assign mem_wdata  = r_mem_wdata;
  assign mem_wmask  = r_mem_wmask;

endmodule

// File: tb/tb_npc_lsu.sv
// Directed bench: a 32-bit and a 64-bit unit (both TIMEOUT=4) driven by shared stimulus.
module tb_npc_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_wen, resp_ready, mem_ready, mem_rvalid;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, mem_rdata;

  logic        req_ready_a, resp_valid_a, mem_valid_a, mem_wen_a;
  logic [31:0] resp_rdata_a, mem_addr_a, mem_wdata_a;
  logic [1:0]  resp_err_a;
  logic [3:0]  mem_wmask_a;

  logic        req_ready_b, resp_valid_b, mem_valid_b, mem_wen_b;
  logic [63:0] resp_rdata_b, mem_wdata_b;
  logic [31:0] mem_addr_b;
  logic [1:0]  resp_err_b;
  logic [7:0]  mem_wmask_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  npc_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready_a), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready), .resp_rdata(resp_rdata_a),
    .resp_err(resp_err_a), .mem_valid(mem_valid_a), .mem_ready(mem_ready),
    .mem_addr(mem_addr_a), .mem_wen(mem_wen_a), .mem_wdata(mem_wdata_a),
    .mem_wmask(mem_wmask_a), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0])
  );

  npc_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(4)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready_b), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready), .resp_rdata(resp_rdata_b),
    .resp_err(resp_err_b), .mem_valid(mem_valid_b), .mem_ready(mem_ready),
    .mem_addr(mem_addr_b), .mem_wen(mem_wen_b), .mem_wdata(mem_wdata_b),
    .mem_wmask(mem_wmask_b), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [63:0] wdata);
    req_valid  = 1'b1;
    req_wen    = wen;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    tick();
    req_valid  = 1'b0;
  endtask

  // Zero-stall memory: mem_ready in cycle 1, mem_rvalid in cycle 2
  task automatic mem_fast(input logic [63:0] rdata);
    mem_ready = 1'b1;
    tick();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();

    chk("rst_req_ready",  req_ready_a,  1);
    chk("rst_resp_valid", resp_valid_a, 0);
    chk("rst_mem_valid",  mem_valid_a,  0);
    chk("rst_mem_wen",    mem_wen_a,    0);
    chk("rst_mem_wmask",  mem_wmask_a,  0);
    chk("rst_resp_err",   resp_err_a,   0);
    chk("rst_resp_rdata", resp_rdata_a, 0);
    chk("rst_mem_addr",   mem_addr_a,   0);
    chk("rst_mem_wdata",  mem_wdata_a,  0);
    chk("rst_b_req_ready", req_ready_b, 1);
    rst = 1'b1;
    tick();

    // lb at offset 3, byte 0x80 sign-extends
    issue(1'b0, 3'b000, 32'h8000_0003, 64'h0);
    chk("lb_c1_mem_valid", mem_valid_a, 1);
    chk("lb_c1_mem_addr",  mem_addr_a,  32'h8000_0000);
    chk("lb_c1_mem_wen",   mem_wen_a,   0);
    chk("lb_c1_mem_wmask", mem_wmask_a, 0);
    chk("lb_c1_req_ready", req_ready_a, 0);
    mem_fast(64'h0000_0000_80FF_1234);
    chk("lb_c3_resp_valid", resp_valid_a, 1);
    chk("lb_c3_rdata",      resp_rdata_a, 32'hFFFF_FF80);
    chk("lb_c3_err",        resp_err_a,   2'b00);
    chk("lb64_c3_rdata",    resp_rdata_b, 64'hFFFF_FFFF_FFFF_FF80);
    consume();
    chk("lb_idle_req_ready", req_ready_a, 1);

    // sh at offset 2; one-cycle mem_ready stall, one-cycle ack stall (handshake on the timeout cycle)
    issue(1'b1, 3'b001, 32'h8000_0002, 64'h0000_ABCD);
    chk("sh_mem_wdata",  mem_wdata_a, 32'hABCD_0000);
    chk("sh_mem_wmask",  mem_wmask_a, 4'b1100);
    chk("sh_mem_wen",    mem_wen_a,   1);
    chk("sh64_mem_wdata", mem_wdata_b, 64'h0000_0000_ABCD_0000);
    chk("sh64_mem_wmask", mem_wmask_b, 8'b0000_1100);
    tick();
    chk("sh_hold_mem_valid", mem_valid_a, 1);
    chk("sh_hold_mem_wdata", mem_wdata_a, 32'hABCD_0000);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("sh_wait_mem_valid",  mem_valid_a,  0);
    tick();
    chk("sh_wait_resp_valid", resp_valid_a, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    chk("sh_resp_valid", resp_valid_a, 1);
    chk("sh_resp_rdata", resp_rdata_a, 0);
    chk("sh_resp_err",   resp_err_a,   2'b00);
    consume();

    // misaligned lw: immediate response held stable under backpressure
    issue(1'b0, 3'b010, 32'h8000_0001, 64'h0);
    for (int k = 0; k < 5; k++) begin
      chk("mis_resp_valid", resp_valid_a, 1);
      chk("mis_resp_err",   resp_err_a,   2'b01);
      chk("mis_mem_valid",  mem_valid_a,  0);
      tick();
    end
    consume();
    chk("mis_done_resp_valid", resp_valid_a, 0);

    // timeout with mem_ready held low
    issue(1'b0, 3'b010, 32'h8000_0004, 64'h0);
    for (int k = 1; k <= 4; k++) begin
      chk("to_mem_valid",  mem_valid_a,  1);
      chk("to_resp_valid", resp_valid_a, 0);
      tick();
    end
    chk("to_resp_valid_c5", resp_valid_a, 1);
    chk("to_resp_err",      resp_err_a,   2'b10);
    chk("to_resp_rdata",    resp_rdata_a, 0);
    consume();
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    chk("late_rvalid_resp_valid", resp_valid_a, 0);
    chk("late_rvalid_req_ready",  req_ready_a,  1);
    chk("late_rvalid_rdata",      resp_rdata_a, 0);

    // lwu at offset 4: legal on 64-bit, illegal on 32-bit
    issue(1'b0, 3'b110, 32'h8000_0004, 64'h0);
    chk("lwu32_resp_valid", resp_valid_a, 1);
    chk("lwu32_err",        resp_err_a,   2'b11);
    chk("lwu32_mem_valid",  mem_valid_a,  0);
    chk("lwu64_mem_valid",  mem_valid_b,  1);
    chk("lwu64_mem_addr",   mem_addr_b,   32'h8000_0000);
    resp_ready = 1'b1;
    mem_fast(64'hDEAD_BEEF_0000_0000);
    chk("lwu64_resp_valid", resp_valid_b, 1);
    chk("lwu64_rdata",      resp_rdata_b, 64'h0000_0000_DEAD_BEEF);
    chk("lwu64_err",        resp_err_b,   2'b00);
    tick();
    resp_ready = 1'b0;

    // ld at offset 4: misaligned on 64-bit, illegal on 32-bit
    issue(1'b0, 3'b011, 32'h8000_0004, 64'h0);
    chk("ld64_resp_valid", resp_valid_b, 1);
    chk("ld64_err",        resp_err_b,   2'b01);
    chk("ld64_mem_valid",  mem_valid_b,  0);
    chk("ld32_err",        resp_err_a,   2'b11);
    consume();

    // lw at offset 4 on 64-bit sign-extends; 32-bit sees offset 0
    issue(1'b0, 3'b010, 32'h8000_0004, 64'h0);
    mem_fast(64'hDEAD_BEEF_0000_0000);
    chk("lw64_rdata", resp_rdata_b, 64'hFFFF_FFFF_DEAD_BEEF);
    chk("lw32_rdata", resp_rdata_a, 32'h0000_0000);
    consume();

    // reset while in WAIT, then a fresh lbu
    issue(1'b0, 3'b100, 32'h8000_0002, 64'h0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    rst = 1'b0;
    tick();
    chk("rstw_mem_valid",  mem_valid_a,  0);
    chk("rstw_resp_valid", resp_valid_a, 0);
    chk("rstw_req_ready",  req_ready_a,  1);
    chk("rstw_mem_addr",   mem_addr_a,   0);
    rst = 1'b1;
    tick();
    issue(1'b0, 3'b100, 32'h8000_0002, 64'h0);
    mem_fast(64'h0000_0000_12A5_3456);
    chk("lbu_resp_valid", resp_valid_a, 1);
    chk("lbu_rdata",      resp_rdata_a, 32'h0000_00A5);
    chk("lbu64_rdata",    resp_rdata_b, 64'h0000_0000_0000_00A5);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
